// File: rtl/aoi211_x4_sync.sv
// aoi211_x4_sync: per-lane AOI211 (zn = ~((c1 & c2) | b | a)) with a registered output and a combinational mirror
module aoi211_x4_sync #(
    parameter int WIDTH = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c1,
    input  logic [WIDTH-1:0] c2,
    output logic [WIDTH-1:0] zn,
    output logic [WIDTH-1:0] zn_comb
);
    logic [WIDTH-1:0] f;
    always_comb f = ~((c1 & c2) | b | a);
    assign zn_comb = f;
    always_ff @(posedge clk) begin
        if (rst) zn <= RST_VAL;
        else if (en) zn <= f;
    end
endmodule

// File: tb/tb_aoi211_x4_sync.sv
// tb_aoi211_x4_sync: table-driven and sequence checks of a 1-lane and a 4-lane instance, zn scored through a queue
module tb_aoi211_x4_sync;
    logic clk = 1'b0;
    logic rst, en;
    logic [3:0] a, b, c1, c2;
    logic [0:0] zn1, znc1;
    logic [3:0] zn4, znc4;
    int n_chk = 0;
    int n_fail = 0;
    logic q1[$];
    logic [3:0] q4[$];
    logic m1;
    logic [3:0] m4;
    typedef struct {
        logic a, b, c1, c2, exp;
    } vec_t;
    vec_t tbl[16];

    always #5 clk = ~clk;

    aoi211_x4_sync #(.WIDTH(1)) u1 (
        .clk(clk), .rst(rst), .en(en), .a(a[0:0]), .b(b[0:0]), .c1(c1[0:0]), .c2(c2[0:0]),
        .zn(zn1), .zn_comb(znc1)
    );
    aoi211_x4_sync #(.WIDTH(4)) u4 (
        .clk(clk), .rst(rst), .en(en), .a(a), .b(b), .c1(c1), .c2(c2),
        .zn(zn4), .zn_comb(znc4)
    );

    function automatic logic [3:0] f(input logic [3:0] ia, ib, ic1, ic2);
        return ~((ic1 & ic2) | ib | ia);
    endfunction

    task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    // Drive one cycle of stimulus and push the zn value expected after the next edge.
    task automatic apply(input logic [3:0] ia, ib, ic1, ic2, input logic ien, irst);
        logic [3:0] t;
        a = ia; b = ib; c1 = ic1; c2 = ic2; en = ien; rst = irst;
        t = f(ia, ib, ic1, ic2);
        m4 = irst ? 4'hF : ien ? t : m4;
        m1 = irst ? 1'b1 : ien ? t[0] : m1;
        q1.push_back(m1);
        q4.push_back(m4);
    endtask

    task automatic tick();
        logic e1;
        logic [3:0] e4;
        @(posedge clk);
        #1;
        n_chk++;
        if (q1.size() == 0 || q4.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard: queue empty, got zn4 %b, expected a queued value", zn4);
        end else begin
            n_chk--;
            e1 = q1.pop_front();
            e4 = q4.pop_front();
            chk("sb_zn1", {3'b0, zn1}, {3'b0, e1});
            chk("sb_zn4", zn4, e4);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected end before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] ra, rb, rc1, rc2, held;
        for (int i = 0; i < 16; i++) begin
            tbl[i].a = i[3];
            tbl[i].b = i[2];
            tbl[i].c1 = i[1];
            tbl[i].c2 = i[0];
            tbl[i].exp = (i < 3) ? 1'b1 : 1'b0;
        end
        m1 = 1'bx;
        m4 = 'x;
        #1;
        apply(4'h0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b1);
        tick();
        chk("reset_zn4", zn4, 4'hF);
        chk("reset_zn1", {3'b0, zn1}, 4'h1);

        for (int i = 0; i < 16; i++) begin
            apply({3'b0, tbl[i].a}, {3'b0, tbl[i].b}, {3'b0, tbl[i].c1}, {3'b0, tbl[i].c2}, 1'b1, 1'b0);
            #1;
            chk($sformatf("tt_comb_%0d", i), {3'b0, znc1}, {3'b0, tbl[i].exp});
            tick();
            chk($sformatf("tt_zn_%0d", i), {3'b0, zn1}, {3'b0, tbl[i].exp});
        end

        apply(4'h0, 4'h0, 4'hF, 4'hF, 1'b1, 1'b1);
        tick();
        chk("rst_prio", zn4, 4'hF);
        apply(4'h0, 4'h0, 4'hF, 4'hF, 1'b1, 1'b0);
        tick();
        chk("rst_release", zn4, 4'h0);

        apply(4'h0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0);
        tick();
        chk("hold_load", zn4, 4'hF);
        for (int k = 0; k < 3; k++) begin
            apply(4'hF, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
            #1;
            chk("hold_comb", znc4, 4'h0);
            tick();
            chk("hold_zn", zn4, 4'hF);
        end
        apply(4'hF, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0);
        tick();
        chk("hold_release", zn4, 4'h0);

        apply(4'b0001, 4'b0010, 4'b1100, 4'b0100, 1'b1, 1'b0);
        #1;
        chk("lane_comb", znc4, 4'b1000);
        tick();
        chk("lane_zn", zn4, 4'b1000);

        for (int k = 0; k < 6; k++) begin
            apply(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 1'b1, 1'b0);
            tick();
        end
        // Raise rst between edges: zn must not move until the edge.
        apply(4'h0, 4'h0, 4'hF, 4'h5, 1'b1, 1'b0);
        tick();
        held = zn4;
        ra = 4'($urandom); rb = 4'($urandom); rc1 = 4'($urandom); rc2 = 4'($urandom);
        apply(ra, rb, rc1, rc2, 1'b1, 1'b1);
        #2;
        chk("rst_async_none", zn4, held);
        chk("midrst_comb_pre", znc4, f(ra, rb, rc1, rc2));
        tick();
        chk("midrst_zn", zn4, 4'hF);
        chk("midrst_comb_post", znc4, f(ra, rb, rc1, rc2));
        apply(ra, rb, rc1, rc2, 1'b1, 1'b0);
        tick();

        apply(4'hF, 4'bxxxx, 4'bxxxx, 4'bxxxx, 1'b1, 1'b0);
        #1;
        chk("xdom_comb", znc4, 4'h0);
        tick();
        chk("xdom_zn", zn4, 4'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/aoi211_x4_sync.md
Name: aoi211_x4_sync

Overview:
- Registered AND-OR-INVERT 2-1-1 cell bank: per lane, ZN = NOT((C1 AND C2) OR B OR A).
- Combinational AOI211 core, followed by an output register with clock enable and synchronous active-high reset.
- A combinational mirror output is also provided.
- Used as a drive-strength-4 equivalent logic primitive in synchronous datapaths and for characterisation or regression of the AOI211 function.

Parameters:
- WIDTH, 1, number of independent bitwise lanes (>=1).
- RST_VAL, all ones (WIDTH bits), value loaded into zn on reset; equals the AOI211 result for all-zero inputs.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-high.
- en  in  1  output register enable.
- a  in  WIDTH  OR-term input A, per lane.
- b  in  WIDTH  OR-term input B, per lane.
- c1  in  WIDTH  AND-term input C1, per lane.
- c2  in  WIDTH  AND-term input C2, per lane.
- zn  out  WIDTH  registered AOI211 result.
- zn_comb  out  WIDTH  combinational AOI211 result, zero latency.

Behaviour:
- Lane i function: f[i] = ~((c1[i] & c2[i]) | b[i] | a[i]). All lanes are fully independent, with no cross-lane logic.
- Truth table for one lane, with inputs in the order A B C1 C2:
  - 0000 -> 1
  - 0001 -> 1
  - 0010 -> 1
  - 0011 -> 0
  - Any combination with A=1 or B=1 -> 0
- zn_comb = f continuously. It is unaffected by clk, rst and en.
- zn register, evaluated on rising clk with this priority:
  - rst=1: zn <= RST_VAL, regardless of en or inputs.
  - else en=1: zn <= f(current inputs).
  - else: zn holds its value.
- Latency: zn reflects inputs sampled at edge N from edge N onward. zn_comb has 0 cycles latency.
- Reset is synchronous only. Asserting rst between edges does not change zn until the next rising edge.
- Releasing rst with en=1 loads f at the first edge where rst=0.
- Reset mid-operation: any in-progress value is overwritten with RST_VAL at the edge. There is no other state.
- Before the first clock edge, zn is undefined. The bench must apply rst for at least 1 cycle.
- X/Z on an input propagates per standard gate semantics on that lane only. A dominant 1 on a or b forces a 0 result even if other inputs are X.
- No internal state beyond the WIDTH-bit zn register. No handshakes.

Test Plan:
- Exhaustive truth table, WIDTH=1, en=1: sweep ABC1C2 from 0000 to 1111, one vector per cycle. Required zn = 1,1,1,0 then 0 for all remaining 12 vectors, each 1 cycle after apply. zn_comb must match the same value immediately.
- Reset priority: rst=1, en=1, inputs 0011 (f=0). Required: zn=1 after the edge. With rst=0 at the next edge, zn=0.
- Enable hold: load 0000 (zn=1), then en=0 and apply 1000 for 3 cycles. Required: zn stays 1 and zn_comb=0. Then en=1 gives zn=0 on the next edge.
- Lane independence, WIDTH=4:
  - Inputs: a=4'b0001, b=4'b0010, c1=4'b1100, c2=4'b0100.
  - Required: zn_comb=4'b1000, and zn=4'b1000 one cycle later.
- Mid-operation reset, WIDTH=4: drive random vectors with en=1, then assert rst for 1 cycle. Required: zn=4'b1111 at that edge, with zn_comb unaffected throughout.
- X dominance: a=1, b=X, c1=X, c2=X. Required: zn_comb=0, and zn=0 after the edge.
